uart_tx_arbiter: RTL and testbench

- Bus-master controller that sequences the UART peripheral through its 32-bit register interface.
- After reset it programs the UART parameter and enable registers.
- It then shares the UART transmit path between N_REQ byte-stream requesters, using round-robin arbitration at packet granularity.
- It polls UART status before every data write, so bytes are never written into a full TX FIFO; packets from different requesters are never interleaved.

---
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Bus-master that configures the UART after reset, then shares its TX path between
// N_REQ byte-stream requesters with packet-granular round-robin arbitration.
module uart_tx_arbiter #(
  parameter int          N_REQ     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [6:0]  UART_CFG  = 7'h62,
  parameter logic [1:0]  UART_EN   = 2'b10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic               init_done_o,
  output logic               uart_req_o,
  output logic               uart_we_o,
  output logic [3:0]         uart_be_o,
  output logic [31:0]        uart_addr_o,
  output logic [31:0]        uart_wdata_o,
  input  logic [31:0]        uart_rdata_i,
  input  logic               uart_rvalid_i
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [7:0] OFF_TXDATA = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_ENABLE = 8'h0C;
  localparam logic [7:0] OFF_PARAM  = 8'h10;

  typedef enum logic [2:0] {INIT_CFG, INIT_EN, IDLE, POLL, CHECK, SEND} state_e;

  state_e            state_q, state_d;
  logic              run_q;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              init_done_q, init_done_d;
  logic [PTR_W-1:0]  win_idx;
  logic              win_found;
  logic [PTR_W:0]    cand;
  logic [7:0]        owner_byte;
  logic [PTR_W-1:0]  ptr_after_owner;
  logic [7:0]        bus_off;
  logic              bus_req;
  logic              unused_rdata;

  // run_q holds the bus quiet for the first cycle after reset so every output reads zero then
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= INIT_CFG;
      run_q       <= 1'b0;
      ptr_q       <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      init_done_q <= init_done_d;
    end
  end

  // Round-robin search starting at ptr_q, wrapping modulo N_REQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_REQ)) cand = cand - (PTR_W+1)'(N_REQ);
      if (!win_found && req_valid_i[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  assign owner_byte      = req_data_i[{owner_q, 3'b000} +: 8];
  assign ptr_after_owner = (owner_q == PTR_W'(N_REQ-1)) ? '0 : owner_q + PTR_W'(1);
  assign unused_rdata    = ^{uart_rdata_i[31:2], uart_rdata_i[0]};

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    init_done_d  = init_done_q;
    bus_req      = 1'b0;
    bus_off      = 8'h00;
    uart_we_o    = 1'b0;
    uart_wdata_o = '0;
    req_ready_o  = '0;
    unique case (state_q)
      INIT_CFG: begin
        if (run_q) begin
          bus_req      = 1'b1;
          uart_we_o    = 1'b1;
          bus_off      = OFF_PARAM;
          uart_wdata_o = {25'b0, UART_CFG};
          state_d      = INIT_EN;
        end
      end
      INIT_EN: begin
        bus_req      = 1'b1;
        uart_we_o    = 1'b1;
        bus_off      = OFF_ENABLE;
        uart_wdata_o = {30'b0, UART_EN};
        init_done_d  = 1'b1;
        state_d      = IDLE;
      end
      IDLE: begin
        if (win_found) begin
          owner_d          = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          state_d          = POLL;
        end
      end
      POLL: begin
        bus_req = 1'b1;
        bus_off = OFF_STATUS;
        state_d = CHECK;
      end
      CHECK: begin
        // A full FIFO or a stalled owner both re-poll; the grant is never released here
        if (uart_rvalid_i) begin
          if (uart_rdata_i[1] || !req_valid_i[owner_q]) state_d = POLL;
          else                                         state_d = SEND;
        end
      end
      SEND: begin
        bus_req              = 1'b1;
        uart_we_o            = 1'b1;
        bus_off              = OFF_TXDATA;
        uart_wdata_o         = {24'b0, owner_byte};
        req_ready_o[owner_q] = 1'b1;
        if (req_last_i[owner_q]) begin
          grant_d = '0;
          ptr_d   = ptr_after_owner;
          state_d = IDLE;
        end else begin
          state_d = POLL;
        end
      end
      default: state_d = INIT_CFG;
    endcase
  end

  assign uart_req_o  = bus_req;
  assign uart_be_o   = bus_req ? 4'hF : 4'h0;
  assign uart_addr_o = bus_req ? BASE_ADDR + {24'h0, bus_off} : 32'h0;
  assign grant_o     = grant_q;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: status-register slave model, per-requester byte queues,
// and a scoreboard of expected TX writes in round-robin packet order.
module tb_uart_tx_arbiter;
  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h4000_1000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last  = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_ready, grant;
  logic           init_done, uart_req, uart_we;
  logic [3:0]     uart_be;
  logic [31:0]    uart_addr, uart_wdata;
  logic [31:0]    uart_rdata  = 32'h2;
  logic           uart_rvalid = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .grant_o(grant), .init_done_o(init_done),
    .uart_req_o(uart_req), .uart_we_o(uart_we), .uart_be_o(uart_be),
    .uart_addr_o(uart_addr), .uart_wdata_o(uart_wdata),
    .uart_rdata_i(uart_rdata), .uart_rvalid_i(uart_rvalid)
  );

  typedef struct { int id; logic [7:0] data; } exp_t;
  typedef struct { logic [31:0] off; logic [31:0] data; int cyc; } blog_t;
  typedef struct { logic [3:0] mask; int len; logic [7:0] seed; int full; int lat; int exp_first; } vec_t;

  int         total = 0, bad = 0, cyc = 0;
  exp_t       sb[$];
  logic [8:0] rq[N][$];
  blog_t      init_log[$];
  int         bus_cnt = 0, n_reads = 0, n_tx = 0, first_id = -1;
  int         last_tx_cyc = -1, init_done_cyc = -1;
  int         full_left = 0, lat = 1, scnt = 0, ptr_m = 0;
  bit         last_full = 1'b0;
  logic [N-1:0] ready_prev = '0;
  vec_t       tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit rq_busy();
    for (int k = 0; k < N; k++) if (rq[k].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Expected order: packets served cyclically from the model pointer
  task automatic enqueue_group(input logic [3:0] mask, input int len, input logic [7:0] seed);
    int last_k;
    logic [7:0] b;
    last_k = ptr_m;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (ptr_m + i) % N;
      if (mask[k]) begin
        for (int j = 0; j < len; j++) begin
          b = seed + 8'(k * 4) + 8'(j);
          rq[k].push_back({(j == len - 1), b});
          sb.push_back('{k, b});
        end
        last_k = k;
      end
    end
    ptr_m = (last_k + 1) % N;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((sb.size() != 0 || rq_busy()) && i < 3000) begin
      @(posedge clk); #1;
      i++;
    end
    chk("drain_in_time", 32'(i < 3000), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string name);
    chk(name, {grant, req_ready, init_done, uart_req, uart_we, uart_be} , '0);
    chk(name, uart_addr | uart_wdata, 32'h0);
  endtask

  task automatic chk_init_log();
    chk("init_writes", init_log.size(), 2);
    if (init_log.size() == 2) begin
      chk("init_cfg_addr",  init_log[0].off,  32'h10);
      chk("init_cfg_data",  init_log[0].data, 32'h62);
      chk("init_en_addr",   init_log[1].off,  32'h0C);
      chk("init_en_data",   init_log[1].data, 32'h2);
      chk("init_en_cycle",  init_log[1].cyc,  init_log[0].cyc + 1);
      chk("init_done_cyc",  init_done_cyc,    init_log[0].cyc + 2);
    end
  endtask

  // Negedge monitor, requester drivers and status-register slave
  initial begin
    forever begin
      bit   rv;
      exp_t e;
      logic [8:0] head;
      @(negedge clk);
      cyc++;
      if (init_done && init_done_cyc < 0) init_done_cyc = cyc;
      if (uart_req) begin
        bus_cnt++;
        chk("bus_be", 32'(uart_be), 32'hF);
        if (uart_we && uart_addr == BASE + 32'h4) begin
          n_tx++;
          last_tx_cyc = cyc;
          if (first_id < 0) first_id = oh_idx(grant);
          chk("tx_after_init", 32'(init_done), 32'd1);
          chk("tx_not_full", 32'(last_full), 32'd0);
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_unexpected: got write 0x%0h, want no write (cycle %0d)", uart_wdata, cyc);
          end else begin
            e = sb.pop_front();
            chk("tx_data",  uart_wdata, {24'h0, e.data});
            chk("tx_ready", 32'(req_ready), 32'(1) << e.id);
            chk("tx_grant", 32'(grant), 32'(1) << e.id);
          end
        end else begin
          chk("ready_no_tx", 32'(req_ready), 32'h0);
          if (!uart_we && uart_addr == BASE + 32'h8) n_reads++;
          else init_log.push_back('{uart_addr - BASE, uart_wdata, cyc});
        end
      end else begin
        chk("bus_idle", uart_addr | uart_wdata | {27'h0, uart_we, uart_be}, 32'h0);
        chk("ready_idle", 32'(req_ready), 32'h0);
      end

      for (int k = 0; k < N; k++)
        if (ready_prev[k] && rq[k].size() != 0) void'(rq[k].pop_front());
      ready_prev = req_ready;
      for (int k = 0; k < N; k++) begin
        if (rq[k].size() != 0) begin
          head = rq[k][0];
          req_valid[k]       = 1'b1;
          req_data[8*k +: 8] = head[7:0];
          req_last[k]        = head[8];
        end else begin
          req_valid[k] = 1'b0;
          req_last[k]  = 1'b0;
        end
      end

      rv = (scnt == 1);
      if (scnt != 0) scnt--;
      if (uart_req && !uart_we && uart_addr == BASE + 32'h8) scnt = lat;
      if (rv) begin
        if (full_left > 0) begin
          uart_rdata = 32'h2;
          full_left--;
          last_full = 1'b1;
        end else begin
          uart_rdata = 32'h1;
          last_full = 1'b0;
        end
      end else begin
        uart_rdata = 32'h2;
      end
      uart_rvalid = rv;
    end
  end

  initial begin
    int c0;
    tbl[0] = '{4'b0101, 3, 8'h10, 0, 1, 0};
    tbl[1] = '{4'b1010, 2, 8'h30, 0, 2, 3};
    tbl[2] = '{4'b0001, 2, 8'h50, 5, 1, 0};
    tbl[3] = '{4'b1000, 2, 8'h70, 0, 3, 3};
    tbl[4] = '{4'b1001, 2, 8'h90, 1, 1, 0};
    tbl[5] = '{4'b1111, 1, 8'hB0, 2, 1, 0};
    tbl[6] = '{4'b0110, 2, 8'hD0, 0, 1, 1};

    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset_outputs");
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk_init_log();
    chk("idle_bus_count", bus_cnt, 2);
    chk("init_done_held", 32'(init_done), 32'd1);

    for (int r = 0; r < 7; r++) begin
      full_left = tbl[r].full;
      lat       = tbl[r].lat;
      n_reads   = 0;
      first_id  = -1;
      enqueue_group(tbl[r].mask, tbl[r].len, tbl[r].seed);
      drain();
      chk("grp_first_owner", first_id, tbl[r].exp_first);
      chk("grp_status_reads", n_reads, tbl[r].full + $countones(tbl[r].mask) * tbl[r].len);
      chk("grp_grant_clear", 32'(grant), 32'h0);
    end

    lat = 1;
    full_left = 0;
    rq[1].push_back({1'b1, 8'hA5});
    sb.push_back('{1, 8'hA5});
    ptr_m = 2;
    c0 = cyc;
    drain();
    chk("single_latency", last_tx_cyc, c0 + 4);
    chk("single_grant_clear", 32'(grant), 32'h0);

    n_tx = 0;
    enqueue_group(4'b0100, 4, 8'hE0);
    for (int i = 0; i < 200 && n_tx < 2; i++) begin
      @(posedge clk); #1;
    end
    chk("mid_bytes_sent", n_tx, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_zero_outputs("mid_reset_outputs");
    for (int k = 0; k < N; k++) rq[k].delete();
    sb.delete();
    init_log.delete();
    init_done_cyc = -1;
    first_id = -1;
    ptr_m = 0;
    full_left = 0;
    scnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    enqueue_group(4'b0110, 2, 8'hC0);
    drain();
    chk_init_log();
    chk("post_reset_first", first_id, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
